round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller for the 1 Hz countdown timer datapath.
//  - Loads the timer with a per-round duration and gates its counting.
//  - Handles pause, early success (Hit) and timeout.
//  - Inserts an inter-round gap, shortens each successive round, counts rounds won, and flags game over.
//  - Sits between the rate divider/timer pair and the player inputs.
// PARAMETERS
//  W           8   width of timer load value / round length
//  ROUND_SECS  30  duration of round 1, seconds (must fit W bits)
//  STEP_SECS   5   reduction in duration per subsequent round
//  MIN_SECS    10  floor on round duration
//  NUM_ROUNDS  5   rounds per game (1..15)
//  GAP_TICKS   3   Tick pulses spent in GAP between rounds (0 allowed)
// PORTS
//  Clock           in   1  system clock (CLOCK_50 domain)
//  Reset           in   1  asynchronous, active-low reset
//  Start           in   1  level, synchronous to Clock; rising edge starts a game
//  Pause           in   1  level; high requests pause while RUN
//  Hit             in   1  1-cycle pulse: player succeeded this round
//  Tick            in   1  1-cycle pulse from rate divider (1 Hz)
//  TimerDone       in   1  timer reached 0; cleared by the timer on TimerLoad
//  TimerLoad       out  1  1-cycle pulse: timer loads TimerLoadValue
//  TimerLoadValue  out  W  duration for current round
//  TimerEnable     out  1  timer may decrement on Tick
//  Round           out  4  current round number, 1..NUM_ROUNDS; 0 when idle
//  Score           out  4  rounds won this game
//  State           out  3  FSM state encoding, for debug/LEDs
//  GameOver        out  1  high in OVER
// BEHAVIOUR
//  Reset (async, immediate, no clock edge needed):
//  - Outputs: State=IDLE; all outputs 0.
//  - Internal: len=ROUND_SECS, gap_cnt=0, start_q=0.
//  start_edge = Start & ~start_q; start_q registered every cycle.
//  States:
//  - IDLE: start_edge -> LOAD; Round<=1, Score<=0, len<=ROUND_SECS.
//  - LOAD: TimerLoad=1 for exactly this cycle, TimerLoadValue=len -> RUN.
//  - RUN: TimerEnable=1. Priority, high to low:
//    - Hit -> GAP, Score+1 (saturates at 15).
//    - TimerDone -> GAP, Score unchanged.
//    - Pause -> PAUSED.
//    - A same-cycle Hit and TimerDone count as a hit.
//  - PAUSED: TimerEnable=0; Hit and TimerDone ignored; Pause low -> RUN.
//  - GAP: gap_cnt<=GAP_TICKS on entry; each Tick decrements it. When gap_cnt==0:
//    - if Round==NUM_ROUNDS -> OVER;
//    - else Round+1, len<=(len>=MIN_SECS+STEP_SECS) ? len-STEP_SECS : MIN_SECS, -> LOAD.
//    - GAP_TICKS=0: leave GAP on the cycle after entry.
//  - OVER: GameOver=1; Round and Score hold. start_edge -> reinit as from IDLE, -> LOAD.
//  start_edge outside IDLE/OVER is ignored. Tick outside GAP is ignored by the FSM.
//  TimerDone is sampled only in RUN; the first RUN cycle sees the cleared value.
//  All outputs are registered or decoded from registered state; no combinational input->output paths.
//  TimerLoadValue holds len in every state.
// STRUCTURE
//  - round_seq_pkg (include file): state encodings IDLE=0, LOAD=1, RUN=2, PAUSED=3, GAP=4, OVER=5;
//    next-length clamp function.
//  - Sub-module rise_edge_det: start_q register plus edge output; reset clears it.
//  - Remainder: one FSM, round/score/gap counters.
// TESTING (default parameters)
//  1 Reset, Start 0->1 -> one TimerLoad cycle, TimerLoadValue=30, Round=1; next cycle TimerEnable=1, State=RUN.
//  2 Hit in RUN -> Score=1, GAP; after 3 Ticks -> TimerLoad with value 25, Round=2.
//  3 TimerDone in each of 5 rounds -> load values 30,25,20,15,10; Score=0; then OVER, GameOver=1.
//    With ROUND_SECS=12: round 2 loads 10 (clamp).
//  4 Pause high in RUN -> TimerEnable=0 next cycle; TimerDone pulse ignored; Pause low -> RUN, TimerEnable=1.
//  5 Hit and TimerDone in the same cycle -> Score+1; Start edge during RUN -> no effect.
//  6 Reset low mid-RUN between clock edges -> all outputs 0, State=IDLE immediately.

Source files
------------

// File: rtl/round_seq_pkg.sv
// Shared state encodings and the round-length clamp for the round sequencer.
package round_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_GAP    = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  // Each round is shorter than the last, but never below the floor.
  function automatic int unsigned next_len(input int unsigned len,
                                           input int unsigned step,
                                           input int unsigned min_len);
    return (len >= min_len + step) ? (len - step) : min_len;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Registers a level input and flags the cycle on which it goes from 0 to 1.
module rise_edge_det (
  input  logic Clock,
  input  logic Reset,
  input  logic Din,
  output logic Rise
);

  logic din_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) din_q <= 1'b0;
    else        din_q <= Din;
  end

  assign Rise = Din & ~din_q;

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: loads and gates the countdown timer, tracks rounds,
// score and the inter-round gap, and flags game over.
module round_sequencer
  import round_seq_pkg::*;
#(
  parameter int W          = 8,
  parameter int ROUND_SECS = 30,
  parameter int STEP_SECS  = 5,
  parameter int MIN_SECS   = 10,
  parameter int NUM_ROUNDS = 5,
  parameter int GAP_TICKS  = 3
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Pause,
  input  logic         Hit,
  input  logic         Tick,
  input  logic         TimerDone,
  output logic         TimerLoad,
  output logic [W-1:0] TimerLoadValue,
  output logic         TimerEnable,
  output logic [3:0]   Round,
  output logic [3:0]   Score,
  output logic [2:0]   State,
  output logic         GameOver
);

  localparam int GW = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  state_t         state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [3:0]     score_q, score_d;
  logic [W-1:0]   len_q, len_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [W-1:0]   tlv_q;
  logic           start_edge;

  rise_edge_det u_start_edge (
    .Clock (Clock),
    .Reset (Reset),
    .Din   (Start),
    .Rise  (start_edge)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      score_q <= 4'd0;
      len_q   <= W'(ROUND_SECS);
      gap_q   <= '0;
      tlv_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      score_q <= score_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      // Tracks len_d so the load value is registered and equals len after the first edge.
      tlv_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    score_d = score_q;
    len_d   = len_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          round_d = 4'd1;
          score_d = 4'd0;
          len_d   = W'(ROUND_SECS);
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // A hit wins over a simultaneous timeout.
        if (Hit) begin
          score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
          gap_d   = GW'(GAP_TICKS);
          state_d = S_GAP;
        end else if (TimerDone) begin
          gap_d   = GW'(GAP_TICKS);
          state_d = S_GAP;
        end else if (Pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (!Pause) state_d = S_RUN;
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (round_q == 4'(NUM_ROUNDS)) begin
            state_d = S_OVER;
          end else begin
            round_d = round_q + 4'd1;
            len_d   = W'(next_len(32'(len_q), 32'(STEP_SECS), 32'(MIN_SECS)));
            state_d = S_LOAD;
          end
        end else if (Tick) begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign TimerLoad      = (state_q == S_LOAD);
  assign TimerEnable    = (state_q == S_RUN);
  assign GameOver       = (state_q == S_OVER);
  assign TimerLoadValue = tlv_q;
  assign Round          = round_q;
  assign Score          = score_q;
  assign State          = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a load scoreboard; a second instance
// with a 12 s first round exercises the length clamp.
module tb_round_sequencer;

  localparam int W  = 8;
  localparam int EW = W + 8;

  logic         Clock, Reset, Start, Pause, Hit, Tick, TimerDone;
  logic         TimerLoad, TimerEnable, GameOver;
  logic [W-1:0] TimerLoadValue;
  logic [3:0]   Round, Score;
  logic [2:0]   State;

  logic         TimerLoad2, TimerEnable2, GameOver2;
  logic [W-1:0] TimerLoadValue2;
  logic [3:0]   Round2, Score2;
  logic [2:0]   State2;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp2_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  round_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Pause(Pause), .Hit(Hit),
    .Tick(Tick), .TimerDone(TimerDone), .TimerLoad(TimerLoad),
    .TimerLoadValue(TimerLoadValue), .TimerEnable(TimerEnable), .Round(Round),
    .Score(Score), .State(State), .GameOver(GameOver)
  );

  round_sequencer #(.ROUND_SECS(12)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Pause(Pause), .Hit(Hit),
    .Tick(Tick), .TimerDone(TimerDone), .TimerLoad(TimerLoad2),
    .TimerLoadValue(TimerLoadValue2), .TimerEnable(TimerEnable2), .Round(Round2),
    .Score(Score2), .State(State2), .GameOver(GameOver2)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  // Monitor: every TimerLoad pulse must match the head of the expected queue.
  always @(negedge Clock) begin
    if (Reset && TimerLoad) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL load_unexpected: act=%0d req=none", TimerLoadValue);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("load", {TimerLoadValue, Round, Score}, 32'(e));
      end
    end
    if (Reset && TimerLoad2) begin
      if (exp2_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL load2_unexpected: act=%0d req=none", TimerLoadValue2);
      end else begin
        logic [EW-1:0] e;
        e = exp2_q.pop_front();
        check("load_clamp", {TimerLoadValue2, Round2, Score2}, 32'(e));
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int len1, input int len2, input int rnd, input int sc);
    exp_q.push_back({W'(len1), 4'(rnd), 4'(sc)});
    exp2_q.push_back({W'(len2), 4'(rnd), 4'(sc)});
  endtask

  task automatic do_gap();
    for (int i = 0; i < 3; i++) begin
      Tick = 1'b1;
      cyc();
      Tick = 1'b0;
      if (i < 2) cyc();
    end
    check("still_gap", 32'(State), 32'd4);
  endtask

  task automatic start_game(input int len2);
    Start = 1'b0;
    cyc();
    push(30, len2, 1, 0);
    Start = 1'b1;
    cyc();
    check("load_state", 32'(State), 32'd1);
    cyc();
    check("run_state", 32'(State), 32'd2);
    check("run_enable", 32'(TimerEnable), 32'd1);
  endtask

  task automatic timeout_round();
    TimerDone = 1'b1;
    cyc();
    TimerDone = 1'b0;
    check("timeout_gap", 32'(State), 32'd4);
  endtask

  int lens1[5] = '{30, 25, 20, 15, 10};
  int lens2[5] = '{12, 10, 10, 10, 10};

  initial begin
    Reset = 1'b0; Start = 1'b0; Pause = 1'b0; Hit = 1'b0; Tick = 1'b0; TimerDone = 1'b0;
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_outputs", {TimerLoad, TimerEnable, GameOver, TimerLoadValue, Round, Score}, 32'd0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    cyc();

    // Game 1: hit in round 1, then pause / combined-hit / ignored start, then timeouts
    start_game(12);
    Hit = 1'b1;
    cyc();
    Hit = 1'b0;
    check("hit_score", 32'(Score), 32'd1);
    check("hit_gap", 32'(State), 32'd4);
    do_gap();
    push(25, 10, 2, 1);
    cyc();
    check("r2_round", 32'(Round), 32'd2);
    cyc();

    Pause = 1'b1;
    cyc();
    check("pause_state", 32'(State), 32'd3);
    check("pause_enable", 32'(TimerEnable), 32'd0);
    TimerDone = 1'b1;
    cyc();
    TimerDone = 1'b0;
    Hit = 1'b1;
    cyc();
    Hit = 1'b0;
    check("pause_ignore_state", 32'(State), 32'd3);
    check("pause_ignore_score", 32'(Score), 32'd1);
    Pause = 1'b0;
    cyc();
    check("resume_state", 32'(State), 32'd2);
    check("resume_enable", 32'(TimerEnable), 32'd1);

    Start = 1'b0;
    cyc();
    Start = 1'b1;
    cyc();
    check("start_in_run_state", 32'(State), 32'd2);
    check("start_in_run_round", 32'(Round), 32'd2);

    Hit = 1'b1; TimerDone = 1'b1;
    cyc();
    Hit = 1'b0; TimerDone = 1'b0;
    check("hit_done_score", 32'(Score), 32'd2);
    do_gap();
    push(20, 10, 3, 2);
    cyc();
    cyc();
    timeout_round();
    do_gap();
    push(15, 10, 4, 2);
    cyc();
    cyc();
    timeout_round();
    do_gap();
    push(10, 10, 5, 2);
    cyc();
    cyc();
    timeout_round();
    do_gap();
    cyc();
    check("over_state", 32'(State), 32'd5);
    check("over_flag", 32'(GameOver), 32'd1);
    repeat (3) cyc();
    check("over_hold", {28'd0, Round, Score} , {28'd0, 4'd5, 4'd2});

    // Game 2: timeout every round, from OVER
    start_game(12);
    for (int r = 1; r <= 5; r++) begin
      timeout_round();
      check("g2_score", 32'(Score), 32'd0);
      do_gap();
      if (r < 5) begin
        push(lens1[r], lens2[r], r + 1, 0);
        cyc();
        check("g2_round", 32'(Round), 32'(r + 1));
        cyc();
      end else begin
        cyc();
      end
    end
    check("g2_over", {29'd0, GameOver, GameOver2, 1'b0}, 32'd6);
    check("g2_over_round", 32'(Round), 32'd5);

    // Game 3: asynchronous reset between edges while running
    start_game(12);
    #3 Reset = 1'b0;
    Start = 1'b0;
    #1;
    check("async_rst_state", 32'(State), 32'd0);
    check("async_rst_outputs", {TimerLoad, TimerEnable, GameOver, TimerLoadValue, Round, Score}, 32'd0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    repeat (3) cyc();
    check("queue_empty", 32'(exp_q.size() + exp2_q.size()), 32'd0);
    check("idle_after_rst", 32'(State), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
